// File: rtl/mul_div_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mul_div_unit : iterative 32-bit MULT/MULTU/DIV/DIVU with HI/LO registers
// Revision     : 1.0
// ---------------------------------------------------------------------------
module mul_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        flush,
  input  logic        hilo_read,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_cnt;
  logic        r_is_div;
  logic        r_sign_q;
  logic        r_sign_r;
  logic        r_div0;
  logic [31:0] r_opnd;   // multiplicand for multiply, divisor for divide
  logic [63:0] r_acc;    // product, or {remainder, quotient}

  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_mul_sum;
  logic [32:0] w_div_sh;
  logic [32:0] w_div_diff;
  logic [63:0] w_acc_step;
  logic [63:0] w_prod_fix;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  assign w_a_mag = (op[0] && op_a[31]) ? -op_a : op_a;
  assign w_b_mag = (op[0] && op_b[31]) ? -op_b : op_b;

  assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
  assign w_div_sh   = {r_acc[63:32], r_acc[31]};
  assign w_div_diff = w_div_sh - {1'b0, r_opnd};

  always_comb begin
    w_acc_step = {w_mul_sum, r_acc[31:1]};
    if (r_is_div) begin
      if (w_div_diff[32])
        w_acc_step = {w_div_sh[31:0], r_acc[30:0], 1'b0};
      else
        w_acc_step = {w_div_diff[31:0], r_acc[30:0], 1'b1};
    end
  end

  // Divide-by-zero leaves remainder = |dividend|; re-signing it restores op_a.
  assign w_prod_fix = r_sign_q ? -r_acc : r_acc;

  always_comb begin
    w_res_hi = w_prod_fix[63:32];
    w_res_lo = w_prod_fix[31:0];
    if (r_is_div) begin
      w_res_hi = r_sign_r ? -r_acc[63:32] : r_acc[63:32];
      if (r_div0)
        w_res_lo = 32'hFFFF_FFFF;
      else
        w_res_lo = r_sign_q ? -r_acc[31:0] : r_acc[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (flush) w_state_nxt = IDLE;
               else if (r_cnt == 5'd0) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= 5'd0;
      r_is_div <= 1'b0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_div0   <= 1'b0;
      r_opnd   <= 32'd0;
      r_acc    <= 64'd0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      done     <= 1'b0;
    end else begin
      done <= (r_state == FIX) && !flush;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_is_div <= op[1];
            r_opnd   <= op[1] ? w_b_mag : w_a_mag;
            r_acc    <= {32'd0, (op[1] ? w_a_mag : w_b_mag)};
            r_sign_q <= op[0] & (op_a[31] ^ op_b[31]);
            r_sign_r <= op[0] & op_a[31];
            r_div0   <= (op_b == 32'd0);
            r_cnt    <= 5'd31;
          end else begin
            if (mthi) hi <= op_a;
            if (mtlo) lo <= op_a;
          end
        end
        RUN: begin
          if (!flush) begin
            r_acc <= w_acc_step;
            if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
          end
        end
        FIX: begin
          if (!flush) begin
            hi <= w_res_hi;
            lo <= w_res_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (r_state == RUN) || (r_state == FIX);
  assign stall = busy & (start | mthi | mtlo | hilo_read);

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mul_div_unit : directed vectors with an expected-result queue and monitor
// Revision        : 1.0
// ---------------------------------------------------------------------------
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic        flush = 1'b0;
  logic        hilo_read = 1'b0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  int checks = 0;
  int failures = 0;
  logic [63:0] expq[$];

  mul_div_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .mthi(mthi), .mtlo(mtlo), .flush(flush), .hilo_read(hilo_read),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (expq.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'(0));
      end else begin
        logic [63:0] e;
        e = expq.pop_front();
        chk("result_hi", 64'(hi), 64'(e[63:32]));
        chk("result_lo", 64'(lo), 64'(e[31:0]));
      end
    end
  end

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input logic hr, input logic mt);
    int nb;
    int ns;
    logic got;
    nb = 0; ns = 0; got = 1'b0;
    @(negedge clk);
    start = 1'b1; op = o; op_a = a; op_b = b; hilo_read = hr;
    expq.push_back(exp);
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else begin
        if (busy) nb++;
        if (stall) ns++;
        if (mt && i == 5) begin mtlo = 1'b1; op_a = 32'hDEADBEEF; end
        if (mt && i == 10) mtlo = 1'b0;
      end
    end
    if (!got) begin
      chk("done_timeout", 64'(got), 64'(1));
      expq.delete();
    end
    chk("busy_cycles", 64'(nb), 64'(33));
    if (hr) chk("stall_cycles", 64'(ns), 64'(33));
    chk("busy_in_done", 64'(busy), 64'(0));
    if (hr) chk("stall_in_done", 64'(stall), 64'(0));
    hilo_read = 1'b0;
    @(negedge clk);
    chk("done_single_pulse", 64'(done), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, 1'b0);
    do_op(2'b01, 32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1, 1'b0, 1'b0);
    do_op(2'b11, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 1'b0, 1'b0);
    do_op(2'b10, 32'd100,      32'd7,        64'h00000002_0000000E, 1'b0, 1'b0);
    do_op(2'b10, 32'h1234,     32'd0,        64'h00001234_FFFFFFFF, 1'b0, 1'b0);
    do_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 1'b0);

    // Preload HI/LO, then flush a MULTU partway through.
    @(negedge clk); mthi = 1'b1; op_a = 32'hAAAA0000;
    @(negedge clk); mthi = 1'b0; mtlo = 1'b1; op_a = 32'h5555;
    @(negedge clk); mtlo = 1'b0;
    chk("mthi_write", 64'(hi), 64'(32'hAAAA0000));
    chk("mtlo_write", 64'(lo), 64'(32'h5555));
    start = 1'b1; op = 2'b00; op_a = 32'd7; op_b = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_idle", 64'(busy), 64'(0));
    repeat (40) @(negedge clk);
    chk("flush_hi_kept", 64'(hi), 64'(32'hAAAA0000));
    chk("flush_lo_kept", 64'(lo), 64'(32'h5555));
    do_op(2'b00, 32'd7, 32'd9, 64'h00000000_0000003F, 1'b0, 1'b0);

    // hilo_read held across a DIV, with an mtlo attempt while busy.
    do_op(2'b11, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b1, 1'b1);
    mtlo = 1'b1; op_a = 32'h77;
    @(posedge clk);
    #1 mtlo = 1'b0;
    chk("mtlo_idle", 64'(lo), 64'(32'h77));

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    start = 1'b1; op = 2'b00; op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    chk("arst_hi", 64'(hi), 64'(0));
    chk("arst_lo", 64'(lo), 64'(0));
    expq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    do_op(2'b01, 32'd2, 32'd3, 64'h00000000_00000006, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(expq.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
